// File: rtl/csc_pkg.sv
// Shared types and defaults for the RGB888->YCbCr frame controller.
package csc_pkg;

    localparam int unsigned IMG_W_DEF = 1280;
    localparam int unsigned IMG_H_DEF = 720;
    localparam int unsigned CNT_W_DEF = 12;
    localparam int unsigned MODE_W    = 2;

    typedef enum logic [1:0] {
        CSC_BYPASS = 2'd0,
        CSC_YCBCR  = 2'd1,
        CSC_GRAY   = 2'd2,
        CSC_RSVD   = 2'd3
    } csc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_RUN     = 2'd3
    } csc_state_e;

    // Pending configuration slot (one request deep).
    typedef struct packed {
        logic      valid;
        logic      enable;
        csc_mode_e mode;
    } csc_cfg_t;

    // Reserved mode is run as bypass.
    function automatic csc_mode_e csc_map_mode(input logic [MODE_W-1:0] m);
        csc_map_mode = (m == 2'd3) ? CSC_BYPASS : csc_mode_e'(m);
    endfunction

endpackage

// File: rtl/csc_frame_ctrl_if.sv
// Configuration request channel (valid/ready) for the frame controller.
interface csc_frame_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_mode;
    logic       cfg_enable;

    modport master (output cfg_valid, output cfg_mode, output cfg_enable, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_mode, input cfg_enable, output cfg_ready);
endinterface

// File: rtl/csc_edge_det.sv
// Single-register edge detector; events are valid in the first cycle the new level is seen.
module csc_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_c,
    output logic fall_c
);

    logic sig_q;

    // Remember last cycle's level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= 1'b0;
        else        sig_q <= sig_i;
    end

    assign rise_c = sig_i & ~sig_q;
    assign fall_c = ~sig_i & sig_q;

endmodule

// File: rtl/csc_frame_ctrl.sv
// Frame-synchronous config commit, geometry measurement and settle gating for the CSC pipeline.
module csc_frame_ctrl
    import csc_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    csc_frame_ctrl_if.slave  cfg,
    input  logic             clr_err,
    input  logic             frame_clk,
    input  logic             frame_clk_en,
    input  logic             frame_data_en,
    output logic             csc_en,
    output logic [1:0]       csc_mode,
    output logic             pass_en,
    output logic             frame_done,
    output logic             size_err,
    output logic [CNT_W-1:0] pix_cnt,
    output logic [CNT_W-1:0] line_cnt,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    csc_state_e       state_q, state_d;
    csc_cfg_t         pend_q, pend_d;
    csc_mode_e        mode_q, mode_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             csc_en_q, csc_en_d;
    logic             pass_en_q, pass_en_d;
    logic             frame_done_q, frame_done_d;
    logic             size_err_q, size_err_d;
    logic [CNT_W-1:0] pix_q, pix_d, pix_seen;
    logic [CNT_W-1:0] line_q, line_d, line_seen;

    logic      vs_rise, vs_fall_unused, hs_rise, hs_fall;
    logic      accept_c, commit_c, mode_chg_c, checking_c, pix_inc_c, new_err_c;
    csc_mode_e new_mode_c;

    csc_edge_det u_vs_det (
        .clk    (sys_clk),
        .rst_n  (rst_n),
        .sig_i  (frame_clk),
        .rise_c (vs_rise),
        .fall_c (vs_fall_unused)
    );

    csc_edge_det u_hs_det (
        .clk    (sys_clk),
        .rst_n  (rst_n),
        .sig_i  (frame_clk_en),
        .rise_c (hs_rise),
        .fall_c (hs_fall)
    );

    // IDLE applies a request right away; otherwise it waits for the frame boundary.
    // A request accepted on a vs_rise is not yet pending, so it rolls to the next frame.
    assign accept_c   = cfg.cfg_valid & cfg_ready_q;
    assign commit_c   = pend_q.valid & ((state_q == ST_IDLE) | vs_rise);
    assign new_mode_c = csc_map_mode(pend_q.mode);
    assign mode_chg_c = (new_mode_c != mode_q);
    assign checking_c = (state_q == ST_SETTLE) | (state_q == ST_RUN);

    // Next state, config slot and registered control outputs.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        mode_d       = mode_q;

        if (commit_c) begin
            pend_d.valid = 1'b0;
            mode_d       = new_mode_c;
        end
        if (accept_c) begin
            pend_d.valid  = 1'b1;
            pend_d.enable = cfg.cfg_enable;
            pend_d.mode   = csc_mode_e'(cfg.cfg_mode);
        end

        case (state_q)
            ST_IDLE: begin
                if (commit_c && pend_q.enable) state_d = ST_WAIT_VS;
            end
            ST_WAIT_VS: begin
                if (vs_rise) state_d = (commit_c && !pend_q.enable) ? ST_IDLE : ST_SETTLE;
            end
            ST_SETTLE, ST_RUN: begin
                if (vs_rise) begin
                    if (commit_c && !pend_q.enable)  state_d = ST_IDLE;
                    else if (commit_c && mode_chg_c) state_d = ST_SETTLE;
                    else                             state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cfg_ready_d  = ~pend_d.valid;
        csc_en_d     = (state_d != ST_IDLE);
        pass_en_d    = (state_d == ST_RUN);
        frame_done_d = vs_rise & checking_c;
    end

    // Saturating pixel/line counters and sticky geometry check.
    always_comb begin
        pix_inc_c = frame_clk_en & frame_data_en;
        pix_seen  = (pix_inc_c && (pix_q != CNT_MAX)) ? pix_q + CNT_W'(1) : pix_q;
        line_seen = (hs_fall && (line_q != CNT_MAX)) ? line_q + CNT_W'(1) : line_q;
        pix_d     = hs_rise ? CNT_W'(pix_inc_c) : pix_seen;
        line_d    = vs_rise ? CNT_W'(hs_fall) : line_seen;
        if (state_q == ST_IDLE) begin
            pix_d  = '0;
            line_d = '0;
        end
        new_err_c  = checking_c & ((hs_fall & (pix_seen != CNT_W'(IMG_W))) |
                                   (vs_rise & (line_seen != CNT_W'(IMG_H))));
        size_err_d = (size_err_q & ~clr_err) | new_err_c;
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            mode_q       <= CSC_BYPASS;
            cfg_ready_q  <= 1'b1;
            csc_en_q     <= 1'b0;
            pass_en_q    <= 1'b0;
            frame_done_q <= 1'b0;
            size_err_q   <= 1'b0;
            pix_q        <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            mode_q       <= mode_d;
            cfg_ready_q  <= cfg_ready_d;
            csc_en_q     <= csc_en_d;
            pass_en_q    <= pass_en_d;
            frame_done_q <= frame_done_d;
            size_err_q   <= size_err_d;
            pix_q        <= pix_d;
            line_q       <= line_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign csc_en        = csc_en_q;
    assign csc_mode      = 2'(mode_q);
    assign pass_en       = pass_en_q;
    assign frame_done    = frame_done_q;
    assign size_err      = size_err_q;
    assign pix_cnt       = pix_q;
    assign line_cnt      = line_q;
    assign state         = 2'(state_q);

endmodule

// File: doc/csc_frame_ctrl.md
Name: csc_frame_ctrl

Overview:
Frame-synchronous controller for the RGB888→YCbCr conversion pipeline. It accepts mode/enable configuration over a valid/ready port and holds it in a shadow register. The configuration is committed to the converter only at a frame boundary (rising edge of frame_clk, i.e. vsync), so a frame is never converted with mixed settings. The block also measures frame geometry, flags size errors, and gates the first frame after any mode change so the converter pipeline can settle.

Parameters:
IMG_W, 1280, expected valid pixels per line
IMG_H, 720, expected lines per frame
CNT_W, 12, width of pixel and line counters (must hold IMG_W and IMG_H)

Ports:
sys_clk  in  1  system clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  configuration request
cfg_ready  out  1  configuration slot free
cfg_mode  in  2  0=bypass, 1=YCbCr, 2=Y-only gray, 3=reserved (treated as bypass)
cfg_enable  in  1  requested converter enable
clr_err  in  1  clears size_err
frame_clk  in  1  vsync; rising edge = frame start
frame_clk_en  in  1  href / line active
frame_data_en  in  1  pixel valid
csc_en  out  1  converter enable (committed)
csc_mode  out  2  converter mode (committed)
pass_en  out  1  downstream may consume the current frame
frame_done  out  1  one-cycle pulse: a frame completed
size_err  out  1  sticky geometry error
pix_cnt  out  CNT_W  pixels counted in the current line
line_cnt  out  CNT_W  lines counted in the current frame
state  out  2  FSM state, for debug

Behaviour:
- Reset (asynchronous, rst_n=0): cfg_ready=1; all other outputs 0; state=IDLE; pending register empty.
- Edge detection: frame_clk and frame_clk_en are registered once. vs_rise / hs_rise / hs_fall are derived from the current input vs the registered value. Internal events therefore fire in the first cycle the input is seen high (or low).
- Config handshake:
  - Accept when cfg_valid & cfg_ready. Latch {cfg_enable, cfg_mode} into pending; cfg_ready→0 the next cycle.
  - Commit in state IDLE: immediate, in the cycle after acceptance.
  - Commit in any other state: at the next vs_rise.
  - cfg_ready→1 in the cycle after commit. At most one request can be pending.
  - Mode 3 is committed to csc_mode as 0.
- FSM states, with transitions evaluated on commit or vs_rise:
  - IDLE (0): csc_en=0, pass_en=0. A commit with enable=1 → WAIT_VS.
  - WAIT_VS (1): csc_en=1, pass_en=0. vs_rise → SETTLE. A commit with enable=0 → IDLE.
  - SETTLE (2): first frame after enable or mode change; pass_en=0. vs_rise → RUN, or → SETTLE again if a mode change commits on that same edge.
  - RUN (3): pass_en=1. vs_rise with a mode change commits → SETTLE.
  - From SETTLE or RUN, a commit with enable=0 at vs_rise → IDLE.
  - A commit with unchanged mode and enable=1 keeps the current state.
- Counters:
  - pix_cnt clears on hs_rise and increments when frame_clk_en & frame_data_en.
  - line_cnt clears on vs_rise and increments on hs_fall.
  - Both counters saturate at 2^CNT_W-1 (no wrap).
  - Counters run in every state except IDLE; in IDLE they are held at 0.
- Checks (SETTLE/RUN only):
  - On hs_fall: if pix_cnt (including a pixel valid in that cycle) ≠ IMG_W, set size_err.
  - On vs_rise: pulse frame_done; if line_cnt ≠ IMG_H, set size_err.
- size_err is sticky until clr_err. If clr_err and a new error occur in the same cycle, the error wins (size_err stays 1).
- Simultaneous cfg acceptance and vs_rise: the new request is accepted into pending and commits at the following vs_rise, not the current one.
- Reset mid-frame: everything returns to IDLE; the partial frame is never reported via frame_done.

Decomposition:
- Package csc_pkg: mode encodings (CSC_BYPASS, CSC_YCBCR, CSC_GRAY), FSM state encoding, default IMG_W/IMG_H.
- Sub-module csc_edge_det: register-and-compare rise/fall detector, instantiated once for frame_clk and once for frame_clk_en.

Test Plan:
- Reset, then cfg mode=1 enable=1 while IDLE → csc_en=1, csc_mode=1 the cycle after acceptance; state=WAIT_VS; cfg_ready back to 1.
- Drive 3 frames of 720 lines × 1280 pixels → frame 1 pass_en=0 (SETTLE), frames 2–3 pass_en=1; frame_done pulses at each vs_rise after the first; size_err=0.
- In RUN, send cfg mode=2 mid-frame → csc_mode stays 1 until the next vs_rise, then becomes 2; state=SETTLE; pass_en=0 for that frame; cfg_ready=0 until the commit.
- Send a line of 1279 pixels → size_err=1 at that hs_fall. Assert clr_err in the same cycle as a 719-line frame's vs_rise → size_err stays 1. A lone clr_err → 0.
- Assert cfg_valid in the same cycle as vs_rise → commit deferred to the following vs_rise.
- Assert rst_n=0 mid-line → all outputs 0 and cfg_ready=1 asynchronously; no frame_done after release.
